// File: rtl/inst_share_ctrl_pkg.sv
// Shared types for the round-robin compute-unit scheduler: FSM states, the tag carried alongside
// each in-flight operation, and the id-width helper.
package inst_share_ctrl_pkg;

  // Wide enough for the largest supported requester count (16).
  localparam int unsigned MAX_ID_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDrain
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/inst_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request at or after the pointer,
// wrapping from the top index back to zero.
module inst_share_ctrl_rr_arbiter
  import inst_share_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_gnt_id
);

  logic w_found;

  always_comb begin
    o_gnt    = '0;
    o_gnt_id = '0;
    w_found  = 1'b0;
    // Pass 0 covers indices at/above the pointer, pass 1 the wrapped indices below it.
    for (int p = 0; p < 2; p++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_found && i_req[j] && ((p == 0) == (j >= int'(i_ptr)))) begin
          w_found   = 1'b1;
          o_gnt[j]  = 1'b1;
          o_gnt_id  = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/inst_share_ctrl.sv
// Round-robin scheduler sharing one fixed-latency (a,b)->z unit between NUM_REQ requesters;
// results come back in issue order tagged with the owning requester id.
module inst_share_ctrl
  import inst_share_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DW       = 1,
  parameter int unsigned UNIT_LAT = 2,
  localparam int unsigned ID_W = id_width(NUM_REQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  output logic [NUM_REQ-1:0]    o_req_ready,
  input  logic [NUM_REQ*DW-1:0] i_req_a,
  input  logic [NUM_REQ*DW-1:0] i_req_b,
  output logic                  o_unit_valid,
  output logic [DW-1:0]         o_unit_a,
  output logic [DW-1:0]         o_unit_b,
  input  logic [DW-1:0]         i_unit_z,
  output logic                  o_rsp_valid,
  output logic [ID_W-1:0]       o_rsp_id,
  output logic [DW-1:0]         o_rsp_z,
  input  logic                  i_flush,
  output logic                  o_flush_done,
  output logic                  o_busy
);

  state_e                r_state, w_state_d;
  logic [ID_W-1:0]       r_ptr;
  logic [ID_W-1:0]       w_gnt_id;
  logic [NUM_REQ-1:0]    w_gnt;
  logic                  w_grant_en;
  logic                  w_hs;
  logic                  w_drained;
  logic                  w_flush_pulse;
  logic                  r_flush_ack;
  logic                  r_flush_done;
  logic                  r_unit_valid;
  logic [DW-1:0]         r_unit_a;
  logic [DW-1:0]         r_unit_b;
  logic [ID_W-1:0]       r_issue_id;
  tag_t                  r_tag [UNIT_LAT];
  tag_t                  w_tag_out;
  logic                  r_rsp_valid;
  logic [ID_W-1:0]       r_rsp_id;
  logic [DW-1:0]         r_rsp_z;

  inst_share_ctrl_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_req    (i_req_valid),
    .i_ptr    (r_ptr),
    .o_gnt    (w_gnt),
    .o_gnt_id (w_gnt_id)
  );

  assign o_req_ready = w_grant_en ? w_gnt : '0;
  assign w_hs        = |(i_req_valid & o_req_ready);
  assign w_tag_out   = r_tag[UNIT_LAT-1];

  // Nothing left to reach the response register; the response stage itself has no
  // backpressure, so it is empty by the following cycle.
  always_comb begin
    w_drained = !r_unit_valid;
    for (int k = 0; k < UNIT_LAT; k++) begin
      if (r_tag[k].valid) w_drained = 1'b0;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_grant_en    = 1'b0;
    w_flush_pulse = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_flush) begin
          w_state_d = StDrain;
        end else begin
          w_grant_en = !i_rst;
          if (w_hs) w_state_d = StBusy;
        end
      end
      StBusy: begin
        if (i_flush) begin
          w_state_d = StDrain;
        end else begin
          w_grant_en = !i_rst;
          if (!w_hs && w_drained) w_state_d = StIdle;
        end
      end
      StDrain: begin
        if (w_drained) begin
          w_state_d     = StIdle;
          w_flush_pulse = !r_flush_ack;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_ptr        <= '0;
      r_flush_ack  <= 1'b0;
      r_flush_done <= 1'b0;
      r_unit_valid <= 1'b0;
      r_unit_a     <= '0;
      r_unit_b     <= '0;
      r_issue_id   <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_z      <= '0;
      for (int k = 0; k < UNIT_LAT; k++) r_tag[k] <= '0;
    end else begin
      r_state      <= w_state_d;
      r_flush_done <= w_flush_pulse;
      // One done pulse per flush assertion; re-arms only once flush drops.
      if (!i_flush) begin
        r_flush_ack <= 1'b0;
      end else if (w_flush_pulse) begin
        r_flush_ack <= 1'b1;
      end
      if (w_hs) begin
        r_ptr      <= (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
        r_unit_a   <= i_req_a[w_gnt_id*DW +: DW];
        r_unit_b   <= i_req_b[w_gnt_id*DW +: DW];
        r_issue_id <= w_gnt_id;
      end
      r_unit_valid <= w_hs;
      r_tag[0]     <= {r_unit_valid, MAX_ID_W'(r_issue_id)};
      for (int k = 1; k < UNIT_LAT; k++) r_tag[k] <= r_tag[k-1];
      r_rsp_valid  <= w_tag_out.valid;
      r_rsp_id     <= w_tag_out.valid ? ID_W'(w_tag_out.id) : '0;
      r_rsp_z      <= w_tag_out.valid ? i_unit_z : '0;
    end
  end

  assign o_unit_valid = r_unit_valid;
  assign o_unit_a     = r_unit_a;
  assign o_unit_b     = r_unit_b;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_z      = r_rsp_z;
  assign o_flush_done = r_flush_done;
  assign o_busy       = (r_state != StIdle);

endmodule

// File: tb/tb_inst_share_ctrl.sv
// Directed bench for inst_share_ctrl with an XOR unit model and an in-order response scoreboard.
module tb_inst_share_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic       unit_valid;
  logic       unit_a;
  logic       unit_b;
  logic       unit_z;
  logic       rsp_valid;
  logic [1:0] rsp_id;
  logic       rsp_z;
  logic       flush;
  logic       flush_done;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr    = 0;
  int sb[$];
  int mon_e;
  logic z_p0, z_p1;

  inst_share_ctrl #(
    .NUM_REQ  (4),
    .DW       (1),
    .UNIT_LAT (2)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .o_unit_valid (unit_valid),
    .o_unit_a     (unit_a),
    .o_unit_b     (unit_b),
    .i_unit_z     (unit_z),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_id     (rsp_id),
    .o_rsp_z      (rsp_z),
    .i_flush      (flush),
    .o_flush_done (flush_done),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  // Shared unit model: z = a ^ b, two cycles after the operands are presented.
  always @(posedge clk) begin
    z_p0 <= unit_a ^ unit_b;
    z_p1 <= z_p0;
  end
  assign unit_z = z_p1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(mon_e >> 1));
        chk("rsp_z", 32'(rsp_z), 32'(mon_e & 1));
      end
    end
  end

  function automatic int rr_pick(input logic [3:0] v, input int ptr);
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = (ptr + k) % 4;
      if (v[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic drive(input logic [3:0] v, input logic [3:0] a, input logic [3:0] b,
                       input logic fl, input logic rs);
    @(posedge clk);
    #1;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    flush     = fl;
    rst       = rs;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
  endtask

  // Drive one request cycle; expect a grant only when ok is set and flush is low.
  task automatic req(input logic [3:0] v, input logic [3:0] a, input logic [3:0] b,
                     input logic fl, input bit ok, input bit track);
    int g;
    logic [1:0] gi;
    drive(v, a, b, fl, 1'b0);
    g = (ok && !fl) ? rr_pick(v, m_ptr) : -1;
    chk("req_ready", 32'(req_ready), (g >= 0) ? 32'(1 << g) : 32'd0);
    if (g >= 0) begin
      gi = g[1:0];
      if (track) sb.push_back(g * 2 + int'(a[gi] ^ b[gi]));
      m_ptr = (g + 1) % 4;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      idle();
    end
    idle();
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; flush = 1'b0;
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_unit_valid", 32'(unit_valid), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    idle();

    // Single op from requester 2: issue T+1, response T+4, idle at T+5.
    req(4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1);
    idle();
    chk("single_unit_valid", 32'(unit_valid), 32'd1);
    chk("single_unit_a", 32'(unit_a), 32'd1);
    chk("single_unit_b", 32'(unit_b), 32'd0);
    idle();
    chk("single_unit_valid_drop", 32'(unit_valid), 32'd0);
    idle();
    chk("single_rsp_early", 32'(rsp_valid), 32'd0);
    idle();
    chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("single_busy_hi", 32'(busy), 32'd1);
    idle();
    chk("single_busy_lo", 32'(busy), 32'd0);

    // Pointer now 3: wrap to 1, then 1,2 valid -> 2, then 3 to bring the pointer to 0.
    req(4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b1);
    req(4'b0110, 4'b0100, 4'b0110, 1'b0, 1'b1, 1'b1);
    req(4'b1000, 4'b1000, 4'b1000, 1'b0, 1'b1, 1'b1);
    drain();

    // All four held for eight cycles: 0,1,2,3,0,1,2,3 back to back.
    for (int i = 0; i < 8; i++) begin
      req(4'b1111, 4'($urandom), 4'($urandom), 1'b0, 1'b1, 1'b1);
    end
    drain();

    // Flush with three ops in flight: grants stop at once, done one cycle after last rsp.
    for (int i = 0; i < 3; i++) begin
      req(4'b1111, 4'($urandom), 4'($urandom), 1'b0, 1'b1, 1'b1);
    end
    req(4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      req(4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
      chk("flush_done_early", 32'(flush_done), 32'd0);
    end
    chk("flush_last_rsp", 32'(rsp_valid), 32'd1);
    req(4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    chk("flush_done_pulse", 32'(flush_done), 32'd1);
    chk("flush_rsp_after", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      req(4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
      chk("flush_held_no_repulse", 32'(flush_done), 32'd0);
    end
    idle();
    idle();
    idle();
    chk("flush_drop_done", 32'(flush_done), 32'd0);
    drain();

    // Flush with a request in IDLE: no grant, done exactly two cycles later.
    req(4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0);
    idle();
    chk("idle_flush_done_t1", 32'(flush_done), 32'd0);
    idle();
    chk("idle_flush_done_t2", 32'(flush_done), 32'd1);
    idle();
    chk("idle_flush_done_t3", 32'(flush_done), 32'd0);

    // Reset with two ops in flight: nothing ever returns, pointer back to 0.
    req(4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0);
    req(4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    m_ptr = 0;
    idle();
    chk("mid_rst_unit_valid", 32'(unit_valid), 32'd0);
    chk("mid_rst_unit_a", 32'(unit_a), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_flush_done", 32'(flush_done), 32'd0);
    for (int i = 0; i < 6; i++) idle();
    req(4'b1111, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
